conv_window_feeder: RTL

Line-buffer front end for the convolution kernel. It takes a raster-order pixel stream and emits one vertical column of KERN_SIZE vertically adjacent pixels per accepted pixel, once KERN_SIZE-1 lines have been buffered. It sits directly upstream of conv_kernel and drives that block's din, din_vld and fin_start.

---
 rtl/conv_window_feeder.sv | 98 +++++++++
 1 files changed

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: line-buffered raster to vertical-column converter feeding conv_kernel.
module conv_window_feeder #(
    parameter int DIN_WIDTH    = 8,
    parameter int KERN_SIZE    = 3,
    parameter int FRAME_WIDTH  = 32,
    parameter int FRAME_HEIGHT = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 i_frame_start,
    input  logic                                 i_pix_vld,
    input  logic signed [DIN_WIDTH-1:0]          i_pix,
    output logic                                 o_fout_start,
    output logic                                 o_col_vld,
    output logic [KERN_SIZE-1:0][DIN_WIDTH-1:0]  o_col,
    output logic                                 o_fout_done,
    output logic                                 o_frame_abort
);
    localparam int CW = FRAME_WIDTH  > 1 ? $clog2(FRAME_WIDTH)  : 1;
    localparam int RW = FRAME_HEIGHT > 1 ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [CW-1:0] C_LAST      = CW'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0] R_LAST      = RW'(FRAME_HEIGHT - 1);
    localparam logic [RW-1:0] R_FILL_LAST = RW'(KERN_SIZE - 2);
    localparam logic [RW-1:0] R_FIRST_OUT = RW'(KERN_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

    state_t                             r_state, w_state_nxt;
    logic [CW-1:0]                      r_col_cnt, w_col_nxt, w_c;
    logic [RW-1:0]                      r_row_cnt, w_row_nxt, w_r;
    logic                               w_restart, w_acc, w_eol, w_eof;
    logic                               w_emit, w_start, w_done, w_abort;
    logic [KERN_SIZE-1:0][DIN_WIDTH-1:0] w_col;
    logic [DIN_WIDTH-1:0]               r_lb [KERN_SIZE-1][FRAME_WIDTH];

    // A frame_start beat is always position (0,0); other beats use the running counters.
    assign w_restart = i_pix_vld && i_frame_start;
    assign w_acc     = i_pix_vld && (i_frame_start || r_state != S_IDLE);
    assign w_c       = w_restart ? '0 : r_col_cnt;
    assign w_r       = w_restart ? '0 : r_row_cnt;
    assign w_eol     = w_c == C_LAST;
    assign w_eof     = w_eol && w_r == R_LAST;

    // State, counters and registered outputs; reset clears everything except the line buffers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_col_cnt     <= '0;
            r_row_cnt     <= '0;
            o_col_vld     <= 1'b0;
            o_fout_start  <= 1'b0;
            o_fout_done   <= 1'b0;
            o_frame_abort <= 1'b0;
            o_col         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_col_cnt     <= w_col_nxt;
            r_row_cnt     <= w_row_nxt;
            o_col_vld     <= w_emit;
            o_fout_start  <= w_start;
            o_fout_done   <= w_done;
            o_frame_abort <= w_abort;
            if (w_emit) o_col <= w_col;
        end
    end

    // Next state and counter advance on each accepted beat; last pixel of a frame returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col_cnt;
        w_row_nxt   = r_row_cnt;
        if (w_acc) begin
            w_col_nxt   = w_eol ? '0 : w_c + 1'b1;
            w_row_nxt   = w_eof ? '0 : (w_eol ? w_r + 1'b1 : w_r);
            w_state_nxt = w_eof ? S_IDLE :
                          (w_r >= R_FIRST_OUT || (w_r == R_FILL_LAST && w_eol)) ? S_STREAM : S_FILL;
        end
    end

    // Output decode: a column is produced once KERN_SIZE-1 lines are buffered.
    always_comb begin
        w_emit  = w_acc && w_r >= R_FIRST_OUT;
        w_start = w_emit && w_r == R_FIRST_OUT && w_c == '0;
        w_done  = w_emit && w_eof;
        w_abort = w_restart && r_state != S_IDLE;
        w_col   = '0;
        for (int k = 0; k < KERN_SIZE - 1; k++) w_col[k] = r_lb[k][w_c];
        w_col[KERN_SIZE-1] = i_pix;
    end

    // Line buffers shift up one row at the current column; reads above see pre-write data.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int k = 0; k < KERN_SIZE - 2; k++) r_lb[k][w_c] <= r_lb[k+1][w_c];
            r_lb[KERN_SIZE-2][w_c] <= i_pix;
        end
    end
endmodule
